// File: rtl/adder_pkg.sv
// Shared constants and elaboration-time parameter checks for the
// pipelined adder/subtractor.
package adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // True when the operand width splits evenly into at least one stage.
    function automatic bit params_ok(input int width, input int stages);
        return (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational ripple-carry slice built from full_adder cells. Exposes the
// carry into the top bit so the caller can derive signed overflow.
module add_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [SLICE:0] carry;

    assign carry[0] = ci;

    // One full adder per bit, carry rippling upward.
    generate
        for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
            full_adder u_fa (
                .a  (x[gi]),
                .b  (y[gi]),
                .ci (carry[gi]),
                .s  (s[gi]),
                .co (carry[gi+1])
            );
        end
    endgenerate

    assign co       = carry[SLICE];
    assign c_msb_in = carry[SLICE-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined adder/subtractor: one add_slice per stage, carry registered
// between stages, operand skew and result deskew carried in full-width
// per-stage registers. The whole pipeline advances together under a
// valid/ready handshake.
module pipelined_add_sub
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    generate
        if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
            $fatal(1, "pipelined_add_sub: WIDTH must be a multiple of STAGES and STAGES >= 1");
        end
    endgenerate

    localparam int SLICE = WIDTH / STAGES;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    logic [STAGES-1:0] valid_reg;
    logic [STAGES-1:0] carry_reg;
    logic [STAGES-1:0] sub_reg;
    logic              ovf_reg;
    logic [WIDTH-1:0]  a_reg   [STAGES];
    logic [WIDTH-1:0]  b_reg   [STAGES];
    logic [WIDTH-1:0]  sum_reg [STAGES];

    logic [STAGES-1:0][SLICE-1:0] slice_x;
    logic [STAGES-1:0][SLICE-1:0] slice_y;
    logic [STAGES-1:0][SLICE-1:0] slice_s;
    logic [STAGES-1:0]            slice_ci;
    logic [STAGES-1:0]            slice_co;
    logic [STAGES-1:0]            slice_cmsb;

    // Subtraction is a + ~b + ~cin; B is inverted once on entry so every
    // downstream stage is a plain adder.
    assign b_eff   = (sub == MODE_SUB) ? ~b : b;
    assign cin_eff = (sub == MODE_SUB) ? ~cin : cin;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Stage 0 takes operands straight from the ports; later stages take
    // their slice from the skewed operands and the registered carry.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign slice_x[gi]  = a[gi*SLICE +: SLICE];
                assign slice_y[gi]  = b_eff[gi*SLICE +: SLICE];
                assign slice_ci[gi] = cin_eff;
            end else begin : g_rest
                assign slice_x[gi]  = a_reg[gi-1][gi*SLICE +: SLICE];
                assign slice_y[gi]  = b_reg[gi-1][gi*SLICE +: SLICE];
                assign slice_ci[gi] = carry_reg[gi-1];
            end

            add_slice #(.SLICE(SLICE)) u_slice (
                .x        (slice_x[gi]),
                .y        (slice_y[gi]),
                .ci       (slice_ci[gi]),
                .s        (slice_s[gi]),
                .co       (slice_co[gi]),
                .c_msb_in (slice_cmsb[gi])
            );
        end
    endgenerate

    // Pipeline registers: clear on reset, otherwise shift one stage whenever
    // the output side is free; hold everything during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            carry_reg <= '0;
            sub_reg   <= '0;
            ovf_reg   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_reg[k]   <= '0;
                b_reg[k]   <= '0;
                sum_reg[k] <= '0;
            end
        end else if (advance) begin
            valid_reg[0]            <= in_valid;
            a_reg[0]                <= a;
            b_reg[0]                <= b_eff;
            sub_reg[0]              <= sub;
            carry_reg[0]            <= slice_co[0];
            sum_reg[0]              <= '0;
            sum_reg[0][SLICE-1:0]   <= slice_s[0];
            for (int k = 1; k < STAGES; k++) begin
                valid_reg[k]                  <= valid_reg[k-1];
                a_reg[k]                      <= a_reg[k-1];
                b_reg[k]                      <= b_reg[k-1];
                sub_reg[k]                    <= sub_reg[k-1];
                carry_reg[k]                  <= slice_co[k];
                sum_reg[k]                    <= sum_reg[k-1];
                sum_reg[k][k*SLICE +: SLICE]  <= slice_s[k];
            end
            ovf_reg <= slice_co[STAGES-1] ^ slice_cmsb[STAGES-1];
        end
    end

    assign out_valid = valid_reg[STAGES-1];
    assign sum       = sum_reg[STAGES-1];
    assign cout      = carry_reg[STAGES-1] ^ sub_reg[STAGES-1];
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub: latency and arithmetic corners at
// 16/4, a stalled mixed stream, mid-flight reset, and an exhaustive 4/2 sweep.
module tb_pipelined_add_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;

    logic       in_valid4, in_ready4, cin4, sub4, out_valid4, out_ready4, cout4, ovf4;
    logic [3:0] a4, b4, sum4;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    pipelined_add_sub #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipelined_add_sub #(.WIDTH(4), .STAGES(2)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        a   = v.a;
        b   = v.b;
        cin = v.cin;
        sub = v.sub;
    endtask

    // Reference for the 4-bit sweep, from integer arithmetic: {cout, ovf, sum}.
    function automatic logic [5:0] ref4(input logic [3:0] ra, input logic [3:0] rb,
                                        input logic rc, input logic rs);
        int ua, ub, c, sa, sb, t, st;
        logic [3:0] s;
        logic co, ov;
        ua = int'(ra);
        ub = int'(rb);
        c  = rc ? 1 : 0;
        sa = ra[3] ? ua - 16 : ua;
        sb = rb[3] ? ub - 16 : ub;
        if (!rs) begin
            t  = ua + ub + c;
            co = (t >= 16);
            st = sa + sb + c;
        end else begin
            t  = ua - ub - c;
            co = (t < 0);
            st = sa - sb - c;
        end
        s  = 4'((t + 32) % 16);
        ov = (st > 7) || (st < -8);
        return {co, ov, s};
    endfunction

    // Single beat: verify exact latency, result, and that it is consumed once.
    task automatic run_one(input string tag, input vec_t v);
        drive(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check({tag, "_early"}, 32'(out_valid), 32'd0);
            tick();
        end
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"}, 32'(sum), 32'(v.s));
        check({tag, "_cout"}, 32'(cout), 32'(v.co));
        check({tag, "_ovf"}, 32'(ovf), 32'(v.ov));
        $display("txn %s a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d",
                 tag, v.a, v.b, v.cin, v.sub, sum, cout, ovf);
        tick();
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    vec_t svec [8];
    vec_t dvec;

    initial begin
        int idx, rcv, cyc;
        logic [15:0] expq [$];
        logic [15:0] ent;
        logic [9:0]  iv;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b1;
        a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Directed arithmetic corners.
        dvec = '{16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0}; run_one("add_basic", dvec);
        dvec = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0}; run_one("add_carry", dvec);
        dvec = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1}; run_one("add_ovf", dvec);
        dvec = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0}; run_one("sub_borrow", dvec);
        dvec = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1}; run_one("sub_ovf", dvec);
        dvec = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0}; run_one("sub_bin", dvec);

        // Mixed stream with a three-cycle output stall.
        svec[0] = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
        svec[1] = '{16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b0, 1'b0};
        svec[2] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        svec[3] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        svec[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        svec[5] = '{16'h1000, 16'h0100, 1'b0, 1'b1, 16'h0F00, 1'b0, 1'b0};
        svec[6] = '{16'h1111, 16'h2222, 1'b1, 1'b0, 16'h3334, 1'b0, 1'b0};
        svec[7] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1};
        idx = 0; rcv = 0; cyc = 0;
        while (rcv < 8 && cyc < 60) begin
            in_valid = (idx < 8);
            if (idx < 8) drive(svec[idx]);
            out_ready = !(cyc >= 5 && cyc <= 7);
            #1;
            check("stream_in_ready", 32'(in_ready), (cyc >= 5 && cyc <= 7) ? 32'd0 : 32'd1);
            if (cyc >= 5 && cyc <= 7) begin
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_hold_sum", 32'(sum), 32'(svec[rcv].s));
            end
            if (out_valid && out_ready) begin
                check("stream_sum", 32'(sum), 32'(svec[rcv].s));
                check("stream_cout", 32'(cout), 32'(svec[rcv].co));
                check("stream_ovf", 32'(ovf), 32'(svec[rcv].ov));
                $display("txn stream[%0d] sum=%h cout=%0d ovf=%0d", rcv, sum, cout, ovf);
                rcv++;
            end
            if (in_valid && in_ready) idx++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 32'(rcv), 32'd8);
        for (int k = 0; k < 4; k++) begin
            check("stream_no_dup", 32'(out_valid), 32'd0);
            tick();
        end

        // Reset with three beats in flight.
        for (int k = 0; k < 3; k++) begin
            dvec = '{16'h0101, 16'h0101, 1'b0, 1'b0, 16'h0202, 1'b0, 1'b0};
            drive(dvec);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("pre_rst_out_valid", 32'(out_valid), 32'd0);
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        $display("txn reset_in_flight out_valid=%0d sum=%h", out_valid, sum);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("post_rst_silent", 32'(out_valid), 32'd0);
        end

        // Exhaustive 4-bit / 2-stage sweep with random back-pressure.
        idx = 0; rcv = 0; cyc = 0;
        while (rcv < 1024 && cyc < 6000) begin
            in_valid4 = (idx < 1024);
            iv = 10'(idx);
            a4 = iv[3:0]; b4 = iv[7:4]; cin4 = iv[8]; sub4 = iv[9];
            out_ready4 = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid4 && out_ready4) begin
                if (expq.size() == 0) begin
                    check("x4_spurious", 32'(out_valid4), 32'd0);
                end else begin
                    ent = expq.pop_front();
                    check("x4_result", 32'({cout4, ovf4, sum4}), 32'(ent[5:0]));
                    $display("txn x4 a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d",
                             ent[9:6], ent[13:10], ent[14], ent[15], sum4, cout4, ovf4);
                end
                rcv++;
            end
            if (in_valid4 && in_ready4) begin
                expq.push_back({iv, ref4(iv[3:0], iv[7:4], iv[8], iv[9])});
                idx++;
            end
            tick();
            cyc++;
        end
        in_valid4 = 1'b0;
        check("x4_count", 32'(rcv), 32'd1024);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
